// File: rtl/nios2_div_pkg.sv
// Shared types and constants for the Nios II iterative divide cell.
package nios2_div_pkg;

    localparam int WIDTH_DEF = 32;
    localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    typedef struct packed {
        logic neg_quo;
        logic neg_rem;
        logic rem_sel;
        logic div_zero;
        logic overflow;
    } div_flags_t;

endpackage

// File: rtl/nios2_div_step.sv
// One restoring-division step: shift {rem,quo} left, subtract the divisor if it fits.
module nios2_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;
    logic           unused_trial_msb;

    // A successful trial is always below the divisor, so its top bit is zero.
    assign shifted          = {rem_i, quo_i[WIDTH-1]};
    assign trial            = shifted - {1'b0, div_i};
    assign fits             = (shifted >= {1'b0, div_i});
    assign unused_trial_msb = trial[WIDTH];

    always_comb begin
        if (fits) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/nios2_qsys_div_cell.sv
// Multi-cycle signed/unsigned integer divider with fixed latency WIDTH+2 from start to done.
module nios2_qsys_div_cell
    import nios2_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             E_div_start,
    input  logic             E_ctrl_div_signed,
    input  logic             E_ctrl_div_rem,
    input  logic [WIDTH-1:0] E_src1_div_cell,
    input  logic [WIDTH-1:0] E_src2_div_cell,
    input  logic             W_div_cancel,
    output logic             div_busy,
    output logic             A_div_cell_done,
    output logic [WIDTH-1:0] A_div_cell_result
);

    localparam logic [WIDTH-1:0] INT_MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    div_flags_t       flags_q, flags_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             src1_neg, src2_neg;
    logic [WIDTH-1:0] src1_mag, src2_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign src1_neg = E_ctrl_div_signed & E_src1_div_cell[WIDTH-1];
    assign src2_neg = E_ctrl_div_signed & E_src2_div_cell[WIDTH-1];
    assign src1_mag = src1_neg ? -E_src1_div_cell : E_src1_div_cell;
    assign src2_mag = src2_neg ? -E_src2_div_cell : E_src2_div_cell;

    nios2_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // With a zero divisor the restoring loop leaves |src1| in rem, so the dividend
    // sign fix reproduces the original src1 exactly; only the quotient is forced.
    always_comb begin
        quo_fix = flags_q.neg_quo ? -quo_q : quo_q;
        rem_fix = flags_q.neg_rem ? -rem_q : rem_q;
        if (flags_q.div_zero) begin
            quo_fix = '1;
        end
        if (flags_q.overflow) begin
            quo_fix = INT_MIN_W;
            rem_fix = '0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        flags_d  = flags_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (E_div_start && !W_div_cancel) begin
                    state_d          = ST_CALC;
                    cnt_d            = CNT_W'(WIDTH);
                    rem_d            = '0;
                    quo_d            = src1_mag;
                    div_d            = src2_mag;
                    flags_d.neg_quo  = src1_neg ^ src2_neg;
                    flags_d.neg_rem  = src1_neg;
                    flags_d.rem_sel  = E_ctrl_div_rem;
                    flags_d.div_zero = (E_src2_div_cell == '0);
                    flags_d.overflow = E_ctrl_div_signed
                                     && (E_src1_div_cell == INT_MIN_W)
                                     && (E_src2_div_cell == '1);
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d  = ST_DONE;
                result_d = flags_q.rem_sel ? rem_fix : quo_fix;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (W_div_cancel && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            flags_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            flags_q  <= flags_d;
            result_q <= result_d;
        end
    end

    assign div_busy          = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign A_div_cell_done   = (state_q == ST_DONE);
    assign A_div_cell_result = result_q;

    // The core stalls on div_busy, so a start seen while busy is a pipeline bug.
    assert property (@(posedge clk) disable iff (!reset_n) !(E_div_start && div_busy))
        else $error("div cell: start issued while busy");

endmodule
